// File: rtl/urv_dmem_bridge.sv
// urv_dmem_bridge
//   Bridges the core's single-access data-memory interface onto a pipelined
//   Wishbone master. Each access runs IDLE -> REQ -> WAIT_ACK -> DONE.
//   Misaligned accesses skip the bus and complete with an error.
//
// Parameters
//   TIMEOUT_CYCLES  Cycles allowed in WAIT_ACK before the cycle is aborted (1..255).
//
// Ports
//   clk_i, rst_n_i    Clock (rising edge) and asynchronous active-low reset.
//   dm_addr_i         Byte address of the access.
//   dm_data_s_i       Store data, with the operand in the low bits.
//   dm_fun_i          Access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
//   dm_load_i         One-cycle load strobe.
//   dm_store_i        One-cycle store strobe. Wins if both strobes are high.
//   dm_data_l_o       Raw load word. Holds until the next load. Cleared on a load error.
//   dm_load_done_o    One-cycle pulse when a load completes.
//   dm_store_done_o   One-cycle pulse when a store completes.
//   dm_error_o        Qualified by a done pulse: misaligned, bus error or timeout.
//   wb_*              Wishbone pipelined master.
module urv_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [2:0]  dm_fun_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_error_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_ACK,
    DONE
  } state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] data_l_q, data_l_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        misal_q, misal_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [3:0]  sel_new;
  logic [31:0] dat_new;
  logic        misal_new;

  // Lane steering and alignment check for the incoming request
  always_comb begin
    sel_new   = '0;
    dat_new   = '0;
    misal_new = 1'b0;
    case (dm_fun_i)
      3'b000, 3'b100: begin
        sel_new = 4'b0001 << dm_addr_i[1:0];
        dat_new = {4{dm_data_s_i[7:0]}};
      end
      3'b001, 3'b101: begin
        sel_new   = dm_addr_i[1] ? 4'b1100 : 4'b0011;
        dat_new   = {2{dm_data_s_i[15:0]}};
        misal_new = dm_addr_i[0];
      end
      3'b010: begin
        sel_new   = 4'b1111;
        dat_new   = dm_data_s_i;
        misal_new = |dm_addr_i[1:0];
      end
      default: misal_new = 1'b1;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    adr_d           = adr_q;
    dat_d           = dat_q;
    data_l_d        = data_l_q;
    sel_d           = sel_q;
    we_d            = we_q;
    misal_d         = misal_q;
    err_d           = err_q;
    cnt_d           = cnt_q;
    wb_cyc_o        = 1'b0;
    wb_stb_o        = 1'b0;
    wb_we_o         = 1'b0;
    wb_sel_o        = '0;
    dm_load_done_o  = 1'b0;
    dm_store_done_o = 1'b0;
    dm_error_o      = 1'b0;

    case (state_q)
      IDLE: begin
        if (dm_store_i || dm_load_i) begin
          adr_d   = {dm_addr_i[31:2], 2'b00};
          sel_d   = sel_new;
          dat_d   = dat_new;
          we_d    = dm_store_i;
          misal_d = misal_new;
          err_d   = misal_new;
          state_d = REQ;
        end
      end

      REQ: begin
        // A misaligned access spends this cycle idle on the bus so that
        // strobe-to-done is exactly two cycles.
        wb_cyc_o = ~misal_q;
        wb_stb_o = ~misal_q;
        wb_we_o  = ~misal_q & we_q;
        wb_sel_o = misal_q ? 4'b0000 : sel_q;
        if (misal_q) begin
          state_d = DONE;
          if (!we_q) data_l_d = '0;
        end else if (!wb_stall_i) begin
          // The slave may answer in the same cycle it accepts the strobe.
          if (wb_err_i) begin
            err_d   = 1'b1;
            state_d = DONE;
            if (!we_q) data_l_d = '0;
          end else if (wb_ack_i) begin
            state_d = DONE;
            if (!we_q) data_l_d = wb_dat_i;
          end else begin
            cnt_d   = '0;
            state_d = WAIT_ACK;
          end
        end
      end

      WAIT_ACK: begin
        wb_cyc_o = 1'b1;
        wb_we_o  = we_q;
        wb_sel_o = sel_q;
        if (wb_err_i || (!wb_ack_i && cnt_q == CntLast)) begin
          err_d   = 1'b1;
          state_d = DONE;
          if (!we_q) data_l_d = '0;
        end else if (wb_ack_i) begin
          state_d = DONE;
          if (!we_q) data_l_d = wb_dat_i;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      DONE: begin
        dm_load_done_o  = ~we_q;
        dm_store_done_o = we_q;
        dm_error_o      = err_q;
        state_d         = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      adr_q    <= '0;
      dat_q    <= '0;
      data_l_q <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
      misal_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      data_l_q <= data_l_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      misal_q  <= misal_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign dm_data_l_o = data_l_q;

endmodule

// File: tb/tb_urv_dmem_bridge.sv
`timescale 1ns/1ps
module tb_urv_dmem_bridge;

  logic        clk_i;
  logic        rst_n_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [2:0]  dm_fun_i;
  logic        dm_load_i;
  logic        dm_store_i;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_error_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  urv_dmem_bridge #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .dm_addr_i      (dm_addr_i),
    .dm_data_s_i    (dm_data_s_i),
    .dm_fun_i       (dm_fun_i),
    .dm_load_i      (dm_load_i),
    .dm_store_i     (dm_store_i),
    .dm_data_l_o    (dm_data_l_o),
    .dm_load_done_o (dm_load_done_o),
    .dm_store_done_o(dm_store_done_o),
    .dm_error_o     (dm_error_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_o       (wb_dat_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i),
    .wb_stall_i     (wb_stall_i)
  );

  typedef struct {
    bit          ld;
    bit          err;
    logic [31:0] data;
    int          lat;
    int          t0;
  } done_t;

  typedef struct {
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    bit          we;
    bit          chk_dat;
    int          stbn;
    int          cycn;
  } bus_t;

  done_t dq[$];
  bus_t  bq[$];

  int tests = 0;
  int fails = 0;
  int cycle = 0;
  int n_done = 0;
  int cyc_total = 0;

  // Slave behaviour: 0 ack, 1 err, 2 ack+err, 3 never answer, 4 ack in the accept cycle
  int          slv_mode = 0;
  int          slv_stall = 0;
  logic [31:0] slv_data = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  initial begin
    clk_i = 1'b0;
    forever begin
      #5 clk_i = 1'b1;
      cycle++;
      #5 clk_i = 1'b0;
    end
  end

  // Wishbone slave
  initial begin
    int  scnt;
    bit  acc;
    bit  now_acc;
    bit  stall;
    bit  a;
    bit  e;
    scnt = 0;
    acc = 0;
    wb_stall_i = 1'b0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!wb_cyc_o) scnt = 0;
      stall = 0;
      if (wb_cyc_o && wb_stb_o) begin
        stall = (scnt < slv_stall);
        scnt++;
      end
      now_acc = wb_cyc_o && wb_stb_o && !stall;
      a = 0;
      e = 0;
      if (slv_mode == 4) a = now_acc;
      else if (acc) begin
        a = (slv_mode == 0) || (slv_mode == 2);
        e = (slv_mode == 1) || (slv_mode == 2);
      end
      wb_stall_i = stall;
      wb_ack_i = a;
      wb_err_i = e;
      wb_dat_i = a ? slv_data : 32'h0;
      acc = now_acc && (slv_mode != 4);
    end
  end

  // Monitor: bus requests and done pulses against the scoreboard
  initial begin
    int   stb_run;
    int   cyc_run;
    bit   have_cur;
    bus_t cur;
    bus_t b;
    done_t d;
    stb_run = 0;
    cyc_run = 0;
    have_cur = 0;
    forever begin
      @(negedge clk_i);
      if (wb_cyc_o && wb_stb_o) stb_run++;
      if (wb_cyc_o && wb_stb_o && !wb_stall_i) begin
        if (bq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_bus: got request adr 0x%08h, expected none", wb_adr_o);
        end else begin
          b = bq.pop_front();
          chk("wb_adr", wb_adr_o, b.adr);
          chk("wb_sel", {28'h0, wb_sel_o}, {28'h0, b.sel});
          chk("wb_we", {31'h0, wb_we_o}, {31'h0, b.we});
          if (b.chk_dat) chk("wb_dat", wb_dat_o, b.dat);
          chk("stb_cycles", 32'(stb_run), 32'(b.stbn));
          cur = b;
          have_cur = 1;
        end
      end
      if (wb_cyc_o) begin
        cyc_run++;
        cyc_total++;
      end else begin
        if (cyc_run > 0 && have_cur && cur.cycn != 0)
          chk("cyc_cycles", 32'(cyc_run), 32'(cur.cycn));
        cyc_run = 0;
        stb_run = 0;
        have_cur = 0;
      end
      if (dm_load_done_o || dm_store_done_o) begin
        n_done++;
        if (dq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got load=%0b store=%0b, expected no done", dm_load_done_o, dm_store_done_o);
        end else begin
          d = dq.pop_front();
          chk("done_onehot", {31'h0, dm_load_done_o & dm_store_done_o}, 32'h0);
          chk("done_is_load", {31'h0, dm_load_done_o}, {31'h0, d.ld});
          chk("done_error", {31'h0, dm_error_o}, {31'h0, d.err});
          chk("done_latency", 32'(cycle - d.t0), 32'(d.lat));
          if (d.ld) chk("load_data", dm_data_l_o, d.data);
        end
      end
    end
  end

  task automatic do_req(
    input bit ld, input bit st, input logic [2:0] fun, input logic [31:0] addr,
    input logic [31:0] sdata, input int mode, input int stall, input logic [31:0] rdata,
    input bit bus, input logic [31:0] eadr, input logic [3:0] esel, input logic [31:0] edat,
    input bit chk_dat, input int stbn, input int cycn,
    input bit done, input bit eerr, input logic [31:0] eload, input int lat);
    bus_t  b;
    done_t d;
    slv_mode = mode;
    slv_stall = stall;
    slv_data = rdata;
    if (bus) begin
      b = '{eadr, esel, edat, st, chk_dat, stbn, cycn};
      bq.push_back(b);
    end
    if (done) begin
      d = '{ld && !st, eerr, eload, lat, cycle};
      dq.push_back(d);
    end
    dm_fun_i = fun;
    dm_addr_i = addr;
    dm_data_s_i = sdata;
    dm_load_i = ld;
    dm_store_i = st;
    @(posedge clk_i);
    #1;
    dm_load_i = 1'b0;
    dm_store_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((dq.size() != 0 || bq.size() != 0) && n < 40) begin
      @(posedge clk_i);
      n++;
    end
    if (dq.size() != 0 || bq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending, expected 0 within 40 cycles", name, dq.size() + bq.size());
      dq.delete();
      bq.delete();
    end
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int d0;
    rst_n_i = 1'b0;
    dm_addr_i = '0;
    dm_data_s_i = '0;
    dm_fun_i = '0;
    dm_load_i = 1'b0;
    dm_store_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, wb_stb_o}, 32'h0);
    chk("rst_we", {31'h0, wb_we_o}, 32'h0);
    chk("rst_sel", {28'h0, wb_sel_o}, 32'h0);
    chk("rst_adr", wb_adr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_data_l", dm_data_l_o, 32'h0);
    chk("rst_done", {30'h0, dm_load_done_o, dm_store_done_o}, 32'h0);
    chk("rst_err", {31'h0, dm_error_o}, 32'h0);
    #2 rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // SB 0x1003, zero-wait
    do_req(0, 1, 3'b000, 32'h1003, 32'h0000_00A5, 0, 0, 32'h0,
           1, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 1, 1, 2, 1, 0, 32'h0, 3);
    wait_idle("sb");
    // LW 0x2000, two stall cycles
    do_req(1, 0, 3'b010, 32'h2000, 32'h0, 0, 2, 32'hDEAD_BEEF,
           1, 32'h2000, 4'b1111, 32'h0, 0, 3, 4, 1, 0, 32'hDEAD_BEEF, 5);
    wait_idle("lw_stall");
    // SH 0x0001 misaligned: no bus cycle
    c0 = cyc_total;
    do_req(0, 1, 3'b001, 32'h0001, 32'h1234, 0, 0, 32'h0,
           0, 32'h0, 4'b0, 32'h0, 0, 0, 0, 1, 1, 32'h0, 2);
    wait_idle("sh_misal");
    chk("sh_misal_no_cyc", 32'(cyc_total - c0), 32'h0);
    // LW 0x3000, slave silent: four WAIT_ACK cycles then timeout
    do_req(1, 0, 3'b010, 32'h3000, 32'h0, 3, 0, 32'h0,
           1, 32'h3000, 4'b1111, 32'h0, 0, 1, 5, 1, 1, 32'h0, 6);
    wait_idle("lw_timeout");
    // LB 0x2002
    do_req(1, 0, 3'b000, 32'h2002, 32'h0, 0, 0, 32'hCAFE_F00D,
           1, 32'h2000, 4'b0100, 32'h0, 0, 1, 2, 1, 0, 32'hCAFE_F00D, 3);
    wait_idle("lb");
    // LH 0x6000 with ack+err together; a store strobe during WAIT_ACK is ignored
    d0 = n_done;
    do_req(1, 0, 3'b001, 32'h6000, 32'h0, 2, 0, 32'h5555_5555,
           1, 32'h6000, 4'b0011, 32'h0, 0, 1, 2, 1, 1, 32'h0, 3);
    @(posedge clk_i);
    #1;
    chk("second_strobe_in_wait", {31'h0, wb_cyc_o & ~wb_stb_o}, 32'h1);
    dm_fun_i = 3'b010;
    dm_addr_i = 32'h0100;
    dm_store_i = 1'b1;
    @(posedge clk_i);
    #1;
    dm_store_i = 1'b0;
    wait_idle("ack_err");
    repeat (4) @(posedge clk_i);
    #1;
    chk("ack_err_single_done", 32'(n_done - d0), 32'h1);
    // LBU 0x7001, slave answers in the accept cycle
    do_req(1, 0, 3'b100, 32'h7001, 32'h0, 4, 0, 32'h0BAD_F00D,
           1, 32'h7000, 4'b0010, 32'h0, 0, 1, 1, 1, 0, 32'h0BAD_F00D, 2);
    wait_idle("lbu_req_ack");
    // Reserved fun 011 is misaligned; load data clears
    do_req(1, 0, 3'b011, 32'h0000, 32'h0, 0, 0, 32'h0,
           0, 32'h0, 4'b0, 32'h0, 0, 0, 0, 1, 1, 32'h0, 2);
    wait_idle("fun011");
    // SH 0x4002
    do_req(0, 1, 3'b001, 32'h4002, 32'h1234_BEEF, 0, 0, 32'h0,
           1, 32'h4000, 4'b1100, 32'hBEEF_BEEF, 1, 1, 2, 1, 0, 32'h0, 3);
    wait_idle("sh");
    // SW 0x5004
    do_req(0, 1, 3'b010, 32'h5004, 32'h89AB_CDEF, 0, 0, 32'h0,
           1, 32'h5004, 4'b1111, 32'h89AB_CDEF, 1, 1, 2, 1, 0, 32'h0, 3);
    wait_idle("sw");
    // SW 0x8002 misaligned
    c0 = cyc_total;
    do_req(0, 1, 3'b010, 32'h8002, 32'h1111_2222, 0, 0, 32'h0,
           0, 32'h0, 4'b0, 32'h0, 0, 0, 0, 1, 1, 32'h0, 2);
    wait_idle("sw_misal");
    chk("sw_misal_no_cyc", 32'(cyc_total - c0), 32'h0);
    // Both strobes: store wins
    do_req(1, 1, 3'b010, 32'h9000, 32'h0F0F_0F0F, 0, 0, 32'h0,
           1, 32'h9000, 4'b1111, 32'h0F0F_0F0F, 1, 1, 2, 1, 0, 32'h0, 3);
    wait_idle("both_strobes");
    // SB 0xA000 with bus error
    do_req(0, 1, 3'b000, 32'hA000, 32'h0000_003C, 1, 0, 32'h0,
           1, 32'hA000, 4'b0001, 32'h3C3C_3C3C, 1, 1, 2, 1, 1, 32'h0, 3);
    wait_idle("sb_err");
    // LW 0xB000
    do_req(1, 0, 3'b010, 32'hB000, 32'h0, 0, 0, 32'h600D_CAFE,
           1, 32'hB000, 4'b1111, 32'h0, 0, 1, 2, 1, 0, 32'h600D_CAFE, 3);
    wait_idle("lw");

    // Reset pulse during WAIT_ACK
    d0 = n_done;
    do_req(1, 0, 3'b010, 32'hC000, 32'h0, 3, 0, 32'h0,
           1, 32'hC000, 4'b1111, 32'h0, 0, 1, 0, 0, 0, 32'h0, 0);
    @(posedge clk_i);
    #1;
    chk("pre_rst_cyc", {31'h0, wb_cyc_o}, 32'h1);
    #1 rst_n_i = 1'b0;
    #1;
    chk("async_rst_cyc", {31'h0, wb_cyc_o}, 32'h0);
    chk("async_rst_adr", wb_adr_o, 32'h0);
    chk("async_rst_data_l", dm_data_l_o, 32'h0);
    #1 rst_n_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1;
    chk("no_done_after_rst", 32'(n_done - d0), 32'h0);
    chk("idle_after_rst", {31'h0, wb_cyc_o}, 32'h0);
    // LHU 0x2 after reset
    do_req(1, 0, 3'b101, 32'h0002, 32'h0, 0, 0, 32'h1234_5678,
           1, 32'h0000, 4'b1100, 32'h0, 0, 1, 2, 1, 0, 32'h1234_5678, 3);
    wait_idle("lhu_after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
